// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants and types for the register file.
//   XLEN   - data width of every register and data port
//   NREGS  - number of architectural registers (including the zero register)
//   ZR_IDX - index of the hard-wired zero register (XZR)
//   ADDR_W - register address width
package regfile_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned ZR_IDX = 31;
    localparam int unsigned ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   data_word_t;

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port.
//   regs_i - flattened view of every register (zero-register slot is ignored)
//   ra_i   - read address
//   rd_o   - read data; 0 for the zero register or any unpopulated address
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = regfile_pkg::XLEN,
    parameter int unsigned NREGS  = regfile_pkg::NREGS,
    parameter int unsigned ZR_IDX = regfile_pkg::ZR_IDX
) (
    input  logic [NREGS-1:0][XLEN-1:0] regs_i,
    input  reg_addr_t                  ra_i,
    output logic [XLEN-1:0]            rd_o
);

    always_comb begin
        rd_o = '0;
        if ((ra_i != ADDR_W'(ZR_IDX)) && (32'(ra_i) < NREGS)) begin
            rd_o = regs_i[ra_i];
        end
    end

endmodule

// File: rtl/regfile.sv
// regfile: NREGS x XLEN register file, two combinational read ports, one
// synchronous write port, hard-wired zero register at ZR_IDX.
//   clk      - clock; writes happen on the rising edge
//   reset    - asynchronous active-high reset; loads Xi = i
//   we3      - write enable, port 3
//   ra1, ra2 - read addresses
//   wa3, wd3 - write address / data
//   rd1, rd2 - read data (no write-to-read bypass)
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = regfile_pkg::XLEN,
    parameter int unsigned NREGS  = regfile_pkg::NREGS,
    parameter int unsigned ZR_IDX = regfile_pkg::ZR_IDX
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we3,
    input  reg_addr_t       ra1,
    input  reg_addr_t       ra2,
    input  reg_addr_t       wa3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    // Read-only view of all registers; the zero slot is a constant, not a flop.
    logic [NREGS-1:0][XLEN-1:0] regs_view;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (i == ZR_IDX) begin : g_zero
            assign regs_view[i] = '0;
        end else begin : g_store
            logic [XLEN-1:0] reg_d;
            logic [XLEN-1:0] reg_q;

            always_comb begin
                reg_d = reg_q;
                if (we3 && (wa3 == ADDR_W'(i))) begin
                    reg_d = wd3;
                end
            end

            // Reset value is the register's own index, zero-extended.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    reg_q <= XLEN'(i);
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_view[i] = reg_q;
        end
    end

    regfile_rdport #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .ZR_IDX (ZR_IDX)
    ) u_rdport1 (
        .regs_i (regs_view),
        .ra_i   (ra1),
        .rd_o   (rd1)
    );

    regfile_rdport #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .ZR_IDX (ZR_IDX)
    ) u_rdport2 (
        .regs_i (regs_view),
        .ra_i   (ra2),
        .rd_o   (rd2)
    );

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and randomized checks of regfile against an array model.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we3;
    logic [4:0]  ra1, ra2, wa3;
    logic [63:0] wd3;
    logic [63:0] rd1, rd2;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model: X0..X30; X31 always reads as zero.
    logic [63:0] model [31];

    always #5 clk = ~clk;

    regfile #(
        .XLEN   (64),
        .NREGS  (32),
        .ZR_IDX (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_rd(input logic [4:0] a);
        return (a == 5'd31) ? 64'd0 : model[a];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 31; i++) model[i] = 64'(i);
    endfunction

    task automatic check_reads(input string tag);
        check({tag, " rd1"}, rd1, ref_rd(ra1));
        check({tag, " rd2"}, rd2, ref_rd(ra2));
    endtask

    // Advance one rising edge, apply its effect to the model, settle 1 ns.
    task automatic step();
        @(posedge clk);
        if (!reset && we3 && wa3 != 5'd31) model[wa3] = wd3;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        we3   = 1'b0;
        ra1   = 5'd3;
        ra2   = 5'd30;
        wa3   = 5'd0;
        wd3   = 64'd0;
        model_reset();
        #1;
        check("rst_ra3", rd1, 64'd3);
        check("rst_ra30", rd2, 64'd30);

        // Write during reset is ignored.
        we3 = 1'b1; wa3 = 5'd2; wd3 = 64'hAAAA; ra1 = 5'd2;
        step();
        check("rst_wr_ignored", rd1, 64'd2);
        reset = 1'b0;
        we3   = 1'b0;

        // Address sweep, both ports on the same address.
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(i);
            #10;
            check("sweep rd1", rd1, (i <= 30) ? 64'(i) : 64'd0);
            check("sweep rd2", rd2, (i <= 30) ? 64'(i) : 64'd0);
        end

        // All-ones write to X5, neighbour untouched.
        we3 = 1'b1; wa3 = 5'd5; wd3 = '1; ra1 = 5'd5; ra2 = 5'd4;
        step();
        check("wr_ones x5", rd1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wr_ones x4", rd2, 64'd4);

        // we3=0 blocks the write.
        we3 = 1'b0; wa3 = 5'd1; wd3 = 64'hFE32; ra2 = 5'd1;
        step();
        check("no_we x1", rd2, 64'd1);

        // Writes to the zero register are dropped.
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'h6E6E6E; ra1 = 5'd31;
        step();
        check("zr_write", rd1, 64'd0);

        // Same-edge write/read: old value before the edge, new value after.
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'h1234; ra1 = 5'd9; ra2 = 5'd9;
        #1;
        check("pre_edge x9 rd1", rd1, 64'd9);
        check("pre_edge x9 rd2", rd2, 64'd9);
        step();
        check("post_edge x9 rd1", rd1, 64'h1234);
        check("post_edge x9 rd2", rd2, 64'h1234);

        // Asynchronous reset mid-operation.
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hDEAD; ra1 = 5'd7;
        step();
        check("x7_dead", rd1, 64'hDEAD);
        we3 = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst x7", rd1, 64'd7);
        check("async_rst x9", dut.u_rdport2.rd_o, 64'd9);
        we3 = 1'b1; wd3 = 64'hBEEF;
        step();
        check("rst_hold x7", rd1, 64'd7);
        // Deassert between edges; the next edge's write is honoured.
        reset = 1'b0;
        step();
        check("rst_release_wr x7", rd1, 64'hBEEF);
        we3 = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            we3 = 1'($urandom_range(0, 1));
            wa3 = 5'($urandom);
            wd3 = {$urandom, $urandom};
            ra1 = 5'($urandom);
            ra2 = 5'($urandom);
            if ($urandom_range(0, 3) == 0) ra1 = wa3;
            if ($urandom_range(0, 5) == 0) ra2 = ra1;
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_reads("rnd_async_rst");
                step();
                check_reads("rnd_rst_hold");
                reset = 1'b0;
            end
            #1;
            check_reads("rnd_pre");
            step();
            check_reads("rnd_post");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
